// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C angle-encoder target.
// Holds the FSM state encoding, register map addresses, data widths and the
// register-map read function used when loading a transmit byte.
package i2c_pkg;

    localparam int unsigned ANGLE_W = 12;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 4;

    // Bit counter codes: last bit of a byte, and "byte load still pending".
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(8);

    localparam logic [BYTE_W-1:0] REG_STATUS      = 8'h0B;
    localparam logic [BYTE_W-1:0] REG_RAW_ANGLE_H = 8'h0C;
    localparam logic [BYTE_W-1:0] REG_RAW_ANGLE_L = 8'h0D;
    localparam logic [BYTE_W-1:0] REG_ANGLE_H     = 8'h0E;
    localparam logic [BYTE_W-1:0] REG_ANGLE_L     = 8'h0F;

    localparam logic [BYTE_W-1:0] STATUS_MAGNET_OK = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_PTR,
        ST_RX_DATA,
        ST_ACK_RX,
        ST_TX_BYTE,
        ST_WAIT_ACK
    } state_t;

    // Read-only register file contents for a given pointer and angle.
    function automatic logic [BYTE_W-1:0] reg_read(
        input logic [BYTE_W-1:0]  ptr,
        input logic [ANGLE_W-1:0] ang
    );
        logic [BYTE_W-1:0] data;
        data = 8'h00;
        if (ptr == REG_STATUS) begin
            data = STATUS_MAGNET_OK;
        end else if (ptr == REG_RAW_ANGLE_H || ptr == REG_ANGLE_H) begin
            data = {4'h0, ang[ANGLE_W-1:8]};
        end else if (ptr == REG_RAW_ANGLE_L || ptr == REG_ANGLE_L) begin
            data = ang[7:0];
        end
        return data;
    endfunction

endpackage

// File: rtl/i2c_angle_target_bus_monitor.sv
// I2C bus monitor: synchronizes SCK/SDA into the clock domain and flags
// START, STOP and SCK rising/falling edges on the synchronized copies.
// Ports:
//   clock, reset_n  system clock, async active-low reset
//   sck, sda_in     raw bus lines
//   sda_sync        synchronized SDA
//   start_c/stop_c  one-cycle START/STOP indications
//   sck_rise_c/sck_fall_c  one-cycle synchronized SCK edge indications
module i2c_bus_monitor #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sck,
    input  logic sda_in,
    output logic sda_sync,
    output logic start_c,
    output logic stop_c,
    output logic sck_rise_c,
    output logic sck_fall_c
);

    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   sck_prev;
    logic                   sda_prev;
    logic                   sck_sync;

    // Synchronizers reset to the idle (released) bus level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_pipe <= '1;
            sda_pipe <= '1;
            sck_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            sck_pipe <= {sck_pipe[SYNC_STAGES-2:0], sck};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            sck_prev <= sck_sync;
            sda_prev <= sda_sync;
        end
    end

    assign sck_sync = sck_pipe[SYNC_STAGES-1];
    assign sda_sync = sda_pipe[SYNC_STAGES-1];

    // SDA transitions count as START/STOP only with SCK stably high.
    assign start_c    = sck_sync & sck_prev & sda_prev & ~sda_sync;
    assign stop_c     = sck_sync & sck_prev & ~sda_prev & sda_sync;
    assign sck_rise_c = sck_sync & ~sck_prev;
    assign sck_fall_c = ~sck_sync & sck_prev;

endmodule

// File: rtl/i2c_angle_target.sv
// I2C target emulating an AS5600-style magnetic angle encoder.
// Optional build macro: I2C_TGT_ANGLE_SNAPSHOT_EN -- when defined, the angle
// is frozen at the read-address ACK so all bytes of one read are coherent.
// Ports:
//   clock, reset_n  system clock (>= 16x SCK), async active-low reset
//   sck, sda_in     I2C bus inputs
//   sda_oe          1 pulls SDA low (open drain)
//   angle           live 12-bit angle
//   busy            addressed, until STOP/START
//   reg_ptr         current register pointer
//   read_done       pulse after each transmitted byte's ACK/NACK is sampled
module i2c_angle_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h36,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sck,
    input  logic               sda_in,
    output logic               sda_oe,
    input  logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic [BYTE_W-1:0]  reg_ptr,
    output logic               read_done
);

    logic sda_sync;
    logic start_c;
    logic stop_c;
    logic sck_rise_c;
    logic sck_fall_c;

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_monitor (
        .clock      (clock),
        .reset_n    (reset_n),
        .sck        (sck),
        .sda_in     (sda_in),
        .sda_sync   (sda_sync),
        .start_c    (start_c),
        .stop_c     (stop_c),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c)
    );

    state_t             state;
    state_t             state_next;
    logic [BYTE_W-1:0]  sreg;
    logic [BYTE_W-1:0]  sreg_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_next;
    logic               rw;
    logic               rw_next;
    logic [BYTE_W-1:0]  reg_ptr_next;
    logic               sda_oe_next;
    logic               busy_next;
    logic               read_done_next;

    logic [BYTE_W-1:0]  shift_in;
    logic               last_bit;
    logic [ANGLE_W-1:0] load_angle;
    logic [BYTE_W-1:0]  tx_byte;

    assign shift_in = {sreg[BYTE_W-2:0], sda_sync};
    assign last_bit = (bit_cnt == CNT_LAST);
    assign tx_byte  = reg_read(reg_ptr, load_angle);

`ifdef I2C_TGT_ANGLE_SNAPSHOT_EN
    logic [ANGLE_W-1:0] snap;

    // First byte loads from the live value at the same edge it is captured.
    assign load_angle = (state == ST_ACK_ADDR) ? angle : snap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
        end else if (state == ST_ACK_ADDR && sck_fall_c && sda_oe && rw
                     && !start_c && !stop_c) begin
            snap <= angle;
        end
    end
`else
    assign load_angle = angle;
`endif

    // State and registered outputs/datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            reg_ptr   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            read_done <= 1'b0;
        end else begin
            state     <= state_next;
            sreg      <= sreg_next;
            bit_cnt   <= bit_cnt_next;
            rw        <= rw_next;
            reg_ptr   <= reg_ptr_next;
            sda_oe    <= sda_oe_next;
            busy      <= busy_next;
            read_done <= read_done_next;
        end
    end

    // Next-state logic. In ACK states sda_oe doubles as "ACK already driven".
    always_comb begin
        state_next = state;
        if (start_c) begin
            state_next = ST_ADDR;
        end else if (stop_c) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR:
                    if (sck_rise_c && last_bit)
                        state_next = (shift_in[7:1] == DEV_ADDR) ? ST_ACK_ADDR : ST_IDLE;
                ST_ACK_ADDR:
                    if (sck_fall_c && sda_oe)
                        state_next = rw ? ST_TX_BYTE : ST_RX_PTR;
                ST_RX_PTR, ST_RX_DATA:
                    if (sck_rise_c && last_bit)
                        state_next = ST_ACK_RX;
                ST_ACK_RX:
                    if (sck_fall_c && sda_oe)
                        state_next = ST_RX_DATA;
                ST_TX_BYTE:
                    if (sck_fall_c && last_bit)
                        state_next = ST_WAIT_ACK;
                ST_WAIT_ACK:
                    if (sck_rise_c)
                        state_next = sda_sync ? ST_IDLE : ST_TX_BYTE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        sreg_next      = sreg;
        bit_cnt_next   = bit_cnt;
        rw_next        = rw;
        reg_ptr_next   = reg_ptr;
        sda_oe_next    = sda_oe;
        busy_next      = busy;
        read_done_next = 1'b0;
        if (start_c) begin
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = '0;
        end else if (stop_c) begin
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else begin
            case (state)
                ST_ADDR:
                    if (sck_rise_c) begin
                        sreg_next    = shift_in;
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt_next = '0;
                            rw_next      = sda_sync;
                            busy_next    = (shift_in[7:1] == DEV_ADDR);
                        end
                    end
                ST_ACK_ADDR:
                    if (sck_fall_c) begin
                        if (!sda_oe) begin
                            sda_oe_next = 1'b1;
                        end else if (rw) begin
                            sreg_next    = tx_byte;
                            sda_oe_next  = ~tx_byte[BYTE_W-1];
                            bit_cnt_next = '0;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                        end
                    end
                ST_RX_PTR, ST_RX_DATA:
                    if (sck_rise_c) begin
                        sreg_next    = shift_in;
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            bit_cnt_next = '0;
                            reg_ptr_next = (state == ST_RX_PTR) ? shift_in
                                                                : reg_ptr + 8'd1;
                        end
                    end
                ST_ACK_RX:
                    if (sck_fall_c)
                        sda_oe_next = ~sda_oe;
                ST_TX_BYTE:
                    if (sck_fall_c) begin
                        if (bit_cnt == CNT_LOAD) begin
                            sreg_next    = tx_byte;
                            sda_oe_next  = ~tx_byte[BYTE_W-1];
                            bit_cnt_next = '0;
                        end else if (last_bit) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                        end else begin
                            // Rotate so the next bit sits in the MSB.
                            sreg_next    = {sreg[BYTE_W-2:0], sreg[BYTE_W-1]};
                            sda_oe_next  = ~sreg[BYTE_W-2];
                            bit_cnt_next = bit_cnt + CNT_W'(1);
                        end
                    end
                ST_WAIT_ACK:
                    if (sck_rise_c) begin
                        read_done_next = 1'b1;
                        reg_ptr_next   = reg_ptr + 8'd1;
                        if (!sda_sync)
                            bit_cnt_next = CNT_LOAD;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_angle_target.sv
// Directed bench for i2c_angle_target: a bus-level initiator model drives
// SCK/SDA, expected read bytes go through a scoreboard queue, and side
// monitors count sda_oe/busy/read_done activity.
module tb_i2c_angle_target;

    localparam time Q = 80ns;   // quarter SCK period

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b1;
    logic        sda_m = 1'b1;
    logic [11:0] angle = 12'h5A3;
    logic        sda_oe;
    logic        busy;
    logic [7:0]  reg_ptr;
    logic        read_done;
    logic        sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_angle_target #(
        .DEV_ADDR    (7'h36),
        .SYNC_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sck       (sck),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .angle     (angle),
        .busy      (busy),
        .reg_ptr   (reg_ptr),
        .read_done (read_done)
    );

    always #5ns clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    int   oe_cycles   = 0;
    int   busy_cycles = 0;
    int   rd_pulses   = 0;
    int   oe_viol     = 0;
    logic oe_prev     = 1'b0;

    always @(negedge clock) begin
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (read_done) rd_pulses <= rd_pulses + 1;
        if (sda_oe && !oe_prev && sck) oe_viol <= oe_viol + 1;
        oe_prev <= sda_oe;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        sck   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        sck   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        sck   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        sck = 1'b1; #(2*Q);
        sck = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        sck = 1'b1; #Q;
        b = sda_line; #Q;
        sck = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic rd8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    // Read one byte, send ACK/NACK, and compare with the scoreboard head.
    task automatic read_cmp(input string tag, input logic nack);
        logic [7:0] d;
        logic [7:0] e;
        rd8(d);
        write_bit(nack);
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(d), 32'(e));
        end
    endtask

    // Set the pointer with a write, then repeated START into a read.
    task automatic set_ptr_then_read(input string tag, input logic [7:0] ptr);
        logic ack;
        i2c_start();
        write_byte(8'h6C, ack); check({tag, "_ack_w"}, 32'(ack), 32'h0);
        write_byte(ptr, ack);   check({tag, "_ack_p"}, 32'(ack), 32'h0);
        i2c_start();
        write_byte(8'h6D, ack); check({tag, "_ack_r"}, 32'(ack), 32'h0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         oe0, busy0, rd0;

        // Reset state
        #23ns;
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_reg_ptr", 32'(reg_ptr), 32'h0);
        check("rst_read_done", 32'(read_done), 32'h0);
        #50ns reset_n = 1'b1;
        #(4*Q);

        // Write pointer 0x0E, repeated START, read 2 bytes of angle 0x5A3
        angle = 12'h5A3;
        rd0 = rd_pulses;
        set_ptr_then_read("t1", 8'h0E);
        check("t1_busy", 32'(busy), 32'h1);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'hA3);
        read_cmp("t1_byte0", 1'b0);
        read_cmp("t1_byte1", 1'b1);
        check("t1_busy_after_nack", 32'(busy), 32'h1);
        i2c_stop();
        #(2*Q);
        check("t1_read_done_count", 32'(rd_pulses - rd0), 32'd2);
        check("t1_reg_ptr", 32'(reg_ptr), 32'h10);
        check("t1_busy_after_stop", 32'(busy), 32'h0);

        // Non-matching address 0x37: never driven, never busy
        oe0 = oe_cycles; busy0 = busy_cycles;
        i2c_start();
        write_byte(8'h6E, ack); check("t2_nack_addr", 32'(ack), 32'h1);
        write_byte(8'h0B, ack); check("t2_nack_data", 32'(ack), 32'h1);
        i2c_stop();
        #(2*Q);
        check("t2_oe_cycles", 32'(oe_cycles - oe0), 32'd0);
        check("t2_busy_cycles", 32'(busy_cycles - busy0), 32'd0);
        check("t2_reg_ptr", 32'(reg_ptr), 32'h10);

        // Pointer wrap from 0xFF
        set_ptr_then_read("t3", 8'hFF);
        check("t3_ptr_set", 32'(reg_ptr), 32'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        read_cmp("t3_byte0", 1'b0);
        read_cmp("t3_byte1", 1'b1);
        i2c_stop();
        #(2*Q);
        check("t3_reg_ptr_wrap", 32'(reg_ptr), 32'h01);

        // Angle changes between the high and low byte
        angle = 12'h123;
        set_ptr_then_read("t4", 8'h0E);
        exp_q.push_back(8'h01);
`ifdef I2C_TGT_ANGLE_SNAPSHOT_EN
        exp_q.push_back(8'h23);
`else
        exp_q.push_back(8'hED);
`endif
        rd8(d);
        angle = 12'hFED;
        write_bit(1'b0);
        check("t4_byte0", 32'(d), 32'(exp_q.pop_front()));
        read_cmp("t4_byte1", 1'b1);
        i2c_stop();
        #(2*Q);

        // Reset while the target pulls SDA low for the status byte MSB
        set_ptr_then_read("t5", 8'h0B);
        check("t5_oe_before_reset", 32'(sda_oe), 32'h1);
        @(posedge clock);
        #3ns reset_n = 1'b0;
        #1ns;
        check("t5_oe_in_reset", 32'(sda_oe), 32'h0);
        check("t5_ptr_in_reset", 32'(reg_ptr), 32'h0);
        #20ns reset_n = 1'b1;
        i2c_stop();
        #(2*Q);
        angle = 12'h5A3;
        set_ptr_then_read("t5b", 8'h0C);
        exp_q.push_back(8'h05);
        read_cmp("t5b_byte0", 1'b1);
        i2c_stop();
        #(2*Q);

        // STOP after four address bits, then a clean status read
        oe0 = oe_cycles; busy0 = busy_cycles;
        i2c_start();
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        #(2*Q);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_oe_cycles", 32'(oe_cycles - oe0), 32'd0);
        check("t6_busy_cycles", 32'(busy_cycles - busy0), 32'd0);
        set_ptr_then_read("t6b", 8'h0B);
        exp_q.push_back(8'h20);
        read_cmp("t6b_status", 1'b1);
        i2c_stop();
        #(2*Q);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("oe_rise_while_sck_high", 32'(oe_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_angle_target.md
Name: i2c_angle_target

Overview:
- I2C target (responder) that emulates the magnetic angle encoder read by the swerve-module angle controller's I2C initiator.
- Presents a live 12-bit angle as AS5600-style registers over open-drain SCK/SDA.
- Used in the FPGA as a loop-back encoder model for bring-up, and in benches as a synthesizable responder in place of a forced SDA.

Parameters:
- DEV_ADDR, 7'h36, 7-bit target address matched after START.
- SYNC_STAGES, 2, flop depth of the SCK/SDA input synchronizers (min 2).

Ports:
- clock  in  1  system clock; must be at least 16x the SCK frequency.
- reset_n  in  1  reset, asynchronous, active-low.
- sck  in  1  I2C clock from initiator; not driven.
- sda_in  in  1  I2C data line as seen on the pad.
- sda_oe  out  1  1 pulls SDA low; 0 releases it (open drain).
- angle  in  12  live angle value to report.
- busy  out  1  high from address match until STOP or START.
- reg_ptr  out  8  current register pointer.
- read_done  out  1  one-cycle pulse after each data byte is transmitted and the initiator's ACK/NACK is sampled.

Behaviour:
- Reset values: sda_oe=0, busy=0, reg_ptr=8'h00, read_done=0; FSM goes to IDLE.
- Reset mid-transfer releases SDA on the same edge.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized copies.
- START: synced SDA 1->0 while synced SCK is 1. STOP: synced SDA 0->1 while synced SCK is 1.
- START or STOP is recognized in every state, including repeated START mid-byte. START goes to ADDR; STOP goes to IDLE. In both cases sda_oe is cleared.
- SDA sampling and driving:
  - Data is sampled on synced SCK rising edge, MSB first.
  - sda_oe changes only on synced SCK falling edge, giving SYNC_STAGES+1 clocks of hold.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1]==DEV_ADDR, go to ACK_ADDR with busy=1. Otherwise go to IDLE and never drive.
  - ACK_ADDR: drive sda_oe=1 for the 9th SCK. On its falling edge, release, then go to RX_PTR if R/W=0 or TX_BYTE if R/W=1.
  - RX_PTR: shift 8 bits into reg_ptr, then go to ACK_RX.
  - RX_DATA: shift 8 bits, then go to ACK_RX. Data is discarded (read-only register file); reg_ptr increments.
  - ACK_RX: drive ACK for one SCK, then go to RX_DATA.
  - TX_BYTE: load the shift register from the register map at the falling edge that ends the ACK. Drive sda_oe=~bit per falling edge. Release after bit 0.
  - WAIT_ACK: sample the initiator's bit on the 9th rising edge and pulse read_done.
    - ACK (0): reg_ptr+1, then TX_BYTE.
    - NACK (1): go to IDLE, but busy holds until STOP/START.
- Register map:
  - 0x0C and 0x0E = {4'h0, angle[11:8]}.
  - 0x0D and 0x0F = angle[7:0].
  - 0x0B (status) = 8'h20 (magnet detected).
  - All others read 8'h00.
- reg_ptr is 8-bit and wraps 0xFF->0x00. The pointer persists across transactions; reset clears it.
- sda_oe never asserts while synced SCK is high, except when holding an ACK/data bit started at the previous falling edge.

Optional Feature:
- I2C_TGT_ANGLE_SNAPSHOT_EN:
  - Defined: angle is captured into a 12-bit holding register at the read-address ACK. All bytes of that read transaction come from the snapshot, so the high/low bytes are coherent.
  - Undefined: each byte samples live angle at its load edge.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum;
  - register address constants REG_RAW_ANGLE_H=8'h0C, REG_ANGLE_H=8'h0E, REG_STATUS=8'h0B;
  - STATUS_MAGNET_OK=8'h20.
- One natural sub-module, i2c_bus_monitor: synchronizers plus START/STOP/SCK-edge detection. It is reusable by the existing initiator for arbitration checks.

Test Plan:
- angle=12'h5A3: write 0x6C,0x0E; repeated START; read 0x6D, 2 bytes, ACK then NACK, STOP -> bytes 0x05,0xA3; three target ACKs; read_done pulses twice; reg_ptr ends at 8'h10.
- Address 0x37 write -> sda_oe stays 0 for the entire transfer; busy stays 0.
- reg_ptr=8'hFF, read 2 bytes -> 0x00 (from 0xFF) then 0x00 (from 0x00); reg_ptr wraps to 8'h01.
- Read from 0x0E with angle changing 12'h123->12'hFED between bytes:
  - with I2C_TGT_ANGLE_SNAPSHOT_EN -> 0x01,0x23;
  - without -> 0x01,0xED.
- reset_n pulsed low mid-TX while sda_oe=1 -> sda_oe=0 immediately; next valid transaction completes normally.
- STOP injected after 4 address bits -> IDLE, no ACK, busy=0; following START/read 0x0B returns 0x20.
